full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Parameterisable ripple-carry full adder: x + y + cin, producing sum A and carry-out cout.
- WIDTH=1 is the classic 1-bit full adder.
- Used as an arithmetic leaf cell in the hardware/simulation co-verification test designs.
- Result is registered by default (1-cycle latency); a parameter selects a purely combinational path.

Parameters:
- WIDTH, 1, operand/sum width in bits (1..64).
- REGISTERED, 1, 1 = outputs registered on clk (latency 1); 0 = outputs combinational from inputs (latency 0; clk/rst only affect the optional counter).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  qualifies x/y/cin in the current cycle
- x  input  WIDTH  operand X, unsigned
- y  input  WIDTH  operand Y, unsigned
- cin  input  1  carry-in
- A  output  WIDTH  sum bits (x+y+cin)[WIDTH-1:0]
- cout  output  1  carry-out, bit WIDTH of x+y+cin
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB
- out_valid  output  1  A/cout/ovf hold a fresh result

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Arithmetic: full sum is x + y + cin computed at WIDTH+1 bits, never truncated before cout is extracted.
  - A = sum[WIDTH-1:0]; cout = sum[WIDTH].
  - ovf = (x[MSB]==y[MSB]) && (A[MSB]!=x[MSB]).
  - Per bit i: s_i = x_i^y_i^c_i; c_{i+1} = x_i&y_i | c_i&(x_i^y_i); c_0 = cin.
- REGISTERED=1:
  - On rising clk with rst=1: A=0, cout=0, ovf=0, out_valid=0.
  - Otherwise, when in_valid=1: capture A/cout/ovf from the current inputs and set out_valid=1 next cycle.
  - When in_valid=0: A/cout/ovf hold their last value; out_valid=0.
  - Back-to-back in_valid gives one result per cycle, with no bubbles.
- REGISTERED=0:
  - A/cout/ovf follow the inputs combinationally at all times, regardless of in_valid and rst.
  - out_valid = in_valid.
  - No reset value exists for the data outputs.
- Reset mid-operation (REGISTERED=1):
  - rst wins over a simultaneous in_valid; that sample is discarded.
  - out_valid=0 the next cycle.
- Boundaries:
  - All-ones + all-ones + cin=1 -> A=all-ones, cout=1.
  - 0+0+0 -> A=0, cout=0, ovf=0.
- Unknown/high-Z inputs: the block does not mask X; X propagates to the affected outputs in simulation.

Optional Feature:
- Macro: FULL_ADDER_CARRY_CNT_EN.
- When defined, the block adds output port carry_count (16 bits).
  - Counts accepted operations (in_valid=1, rst=0, on clk) whose cout=1.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by synchronous rst.
  - Counts the same way for REGISTERED=0, using the combinational cout.
- When not defined: no port, no counter logic, behaviour otherwise identical.

Test Plan:
- WIDTH=1, REGISTERED=0, exhaustive sweep of all 8 {x,y,cin} combinations -> {cout,A} = 00,01,01,10,01,10,10,11 for xyc = 000..111.
- WIDTH=1, REGISTERED=1, rst high 2 cycles then x=1,y=1,cin=1 with in_valid=1 -> next cycle A=1, cout=1, out_valid=1. During reset, A=0, cout=0, out_valid=0.
- WIDTH=8, REGISTERED=1, x=8'hFF, y=8'h01, cin=0 -> A=8'h00, cout=1, ovf=0. Then x=8'h7F, y=8'h01, cin=0 -> A=8'h80, cout=0, ovf=1.
- WIDTH=8, REGISTERED=1, in_valid bursts of 3 back-to-back then idle -> 3 consecutive out_valid pulses with matching sums; outputs hold during idle.
- Assert rst in the same cycle as in_valid=1 with x=8'h10, y=8'h20 -> next cycle out_valid=0, A=0.
- FULL_ADDER_CARRY_CNT_EN defined, WIDTH=1:
  - 5 accepted ops with x=y=1 plus 3 with x=y=0 -> carry_count=5.
  - rst -> carry_count=0.

Source files
------------

// File: rtl/full_adder.sv
// Parameterisable ripple-carry adder (x + y + cin) with optional output register.
// Define FULL_ADDER_CARRY_CNT_EN to add a saturating 16-bit count of carry-out events.
module full_adder #(
  parameter int WIDTH      = 1,
  parameter int REGISTERED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] A,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
`ifdef FULL_ADDER_CARRY_CNT_EN
  ,output logic [15:0]     carry_count
`endif
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_sum[i]       = x[i] ^ y[i] ^ w_carry[i];
    assign w_carry[i + 1] = (x[i] & y[i]) | (w_carry[i] & (x[i] ^ y[i]));
  end

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  if (REGISTERED != 0) begin : g_reg
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sum   <= '0;
        r_cout  <= 1'b0;
        r_ovf   <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        r_valid <= in_valid;
        if (in_valid) begin
          r_sum  <= w_sum;
          r_cout <= w_carry[WIDTH];
          r_ovf  <= w_ovf;
        end
      end
    end

    assign A         = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign out_valid = r_valid;
  end else begin : g_comb
    assign A         = w_sum;
    assign cout      = w_carry[WIDTH];
    assign ovf       = w_ovf;
    assign out_valid = in_valid;
  end

`ifdef FULL_ADDER_CARRY_CNT_EN
  logic [15:0] r_carry_cnt;

  // Counts the carry of the operation being accepted, so both latencies agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry_cnt <= '0;
    end else if (in_valid && w_carry[WIDTH] && (r_carry_cnt != 16'hFFFF)) begin
      r_carry_cnt <= r_carry_cnt + 16'd1;
    end
  end

  assign carry_count = r_carry_cnt;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Randomised self-checking bench for full_adder: combinational and registered
// 1-bit instances plus a registered 8-bit instance, compared to an arithmetic model.
module tb_full_adder;

  typedef struct packed {
    logic [7:0] a;
    logic       co;
    logic       ov;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 1-bit instances share one set of inputs
  logic       v1 = 1'b0;
  logic [0:0] x1 = '0;
  logic [0:0] y1 = '0;
  logic       c1 = 1'b0;
  // 8-bit instance inputs
  logic       v8 = 1'b0;
  logic [7:0] x8 = '0;
  logic [7:0] y8 = '0;
  logic       c8 = 1'b0;

  logic [0:0] c_a, r1_a;
  logic       c_co, c_ov, c_vld, r1_co, r1_ov, r1_vld;
  logic [7:0] r8_a;
  logic       r8_co, r8_ov, r8_vld;
`ifdef FULL_ADDER_CARRY_CNT_EN
  logic [15:0] c_cnt, r1_cnt, r8_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // expected registered outputs and counter models
  res_t e1 = '0;
  res_t e8 = '0;
  logic e1v = 1'b0;
  logic e8v = 1'b0;
  int   m1 = 0;
  int   m8 = 0;

  full_adder #(.WIDTH(1), .REGISTERED(0)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(v1), .x(x1), .y(y1), .cin(c1),
    .A(c_a), .cout(c_co), .ovf(c_ov), .out_valid(c_vld)
`ifdef FULL_ADDER_CARRY_CNT_EN
    , .carry_count(c_cnt)
`endif
  );

  full_adder #(.WIDTH(1), .REGISTERED(1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(v1), .x(x1), .y(y1), .cin(c1),
    .A(r1_a), .cout(r1_co), .ovf(r1_ov), .out_valid(r1_vld)
`ifdef FULL_ADDER_CARRY_CNT_EN
    , .carry_count(r1_cnt)
`endif
  );

  full_adder #(.WIDTH(8), .REGISTERED(1)) u_r8 (
    .clk(clk), .rst(rst), .in_valid(v8), .x(x8), .y(y8), .cin(c8),
    .A(r8_a), .cout(r8_co), .ovf(r8_ov), .out_valid(r8_vld)
`ifdef FULL_ADDER_CARRY_CNT_EN
    , .carry_count(r8_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Plain integer arithmetic: unsigned sum for A/cout, signed range test for ovf.
  function automatic res_t ref_add(input int w, input int x, input int y, input int c);
    res_t r;
    int full, half, sx, sy, ss;
    full = x + y + c;
    half = 1 << (w - 1);
    sx   = (x >= half) ? x - (1 << w) : x;
    sy   = (y >= half) ? y - (1 << w) : y;
    ss   = sx + sy + c;
    r.a  = 8'(full & ((1 << w) - 1));
    r.co = 1'((full >> w) & 1);
    r.ov = (ss >= half) || (ss < -half);
    return r;
  endfunction

  // Called at a falling edge with inputs already driven; checks one full cycle.
  task automatic tick();
    res_t r;
    #1;
    r = ref_add(1, int'(x1), int'(y1), int'(c1));
    check("comb_A", 64'(c_a), 64'(r.a[0]));
    check("comb_cout", 64'(c_co), 64'(r.co));
    check("comb_ovf", 64'(c_ov), 64'(r.ov));
    check("comb_vld", 64'(c_vld), 64'(v1));
    if (rst) begin
      e1 = '0; e1v = 1'b0; m1 = 0;
    end else begin
      e1v = v1;
      if (v1) e1 = r;
      if (v1 && r.co && m1 < 65535) m1++;
    end
    r = ref_add(8, int'(x8), int'(y8), int'(c8));
    if (rst) begin
      e8 = '0; e8v = 1'b0; m8 = 0;
    end else begin
      e8v = v8;
      if (v8) e8 = r;
      if (v8 && r.co && m8 < 65535) m8++;
    end
    @(posedge clk);
    #1;
    check("r1_A", 64'(r1_a), 64'(e1.a[0]));
    check("r1_cout", 64'(r1_co), 64'(e1.co));
    check("r1_ovf", 64'(r1_ov), 64'(e1.ov));
    check("r1_vld", 64'(r1_vld), 64'(e1v));
    check("r8_A", 64'(r8_a), 64'(e8.a));
    check("r8_cout", 64'(r8_co), 64'(e8.co));
    check("r8_ovf", 64'(r8_ov), 64'(e8.ov));
    check("r8_vld", 64'(r8_vld), 64'(e8v));
`ifdef FULL_ADDER_CARRY_CNT_EN
    check("c1_cnt", 64'(c_cnt), 64'(m1));
    check("r1_cnt", 64'(r1_cnt), 64'(m1));
    check("r8_cnt", 64'(r8_cnt), 64'(m8));
`endif
    @(negedge clk);
  endtask

  initial begin
    logic [16:0] dir [4];
    dir[0] = {8'hFF, 8'h01, 1'b0};
    dir[1] = {8'h7F, 8'h01, 1'b0};
    dir[2] = {8'hFF, 8'hFF, 1'b1};
    dir[3] = {8'h00, 8'h00, 1'b0};

    @(negedge clk);
    // reset for two cycles while valid inputs are presented
    rst = 1'b1; v1 = 1'b1; x1 = 1'b1; y1 = 1'b1; c1 = 1'b1;
    v8 = 1'b1; x8 = 8'h10; y8 = 8'h20;
    tick();
    tick();
    rst = 1'b0;

`ifdef FULL_ADDER_CARRY_CNT_EN
    v8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1; c1 = 1'b0;
      x1 = (i < 5) ? 1'b1 : 1'b0;
      y1 = x1;
      tick();
    end
    check("cnt_eq5_comb", 64'(c_cnt), 64'd5);
    check("cnt_eq5_reg", 64'(r1_cnt), 64'd5);
    rst = 1'b1; v1 = 1'b1; x1 = 1'b1; y1 = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_clear", 64'(r1_cnt), 64'd0);
`endif

    // first op after reset: 1+1+1, then exhaustive 1-bit sweep
    v1 = 1'b1; x1 = 1'b1; y1 = 1'b1; c1 = 1'b1; v8 = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      {x1, y1, c1} = 3'(i);
      tick();
    end
    v1 = 1'b0;

    // 8-bit directed boundaries
    for (int i = 0; i < 4; i++) begin
      v8 = 1'b1;
      {x8, y8, c8} = dir[i];
      tick();
    end

    // burst of three, then idle with changing inputs
    for (int i = 0; i < 6; i++) begin
      v8 = (i < 3);
      x8 = 8'($urandom); y8 = 8'($urandom); c8 = 1'($urandom);
      tick();
    end

    // reset colliding with a valid sample
    rst = 1'b1; v8 = 1'b1; x8 = 8'h10; y8 = 8'h20; c8 = 1'b0;
    tick();
    rst = 1'b0; v8 = 1'b0;
    tick();

    // random traffic on all instances
    for (int i = 0; i < 300; i++) begin
      v1 = 1'($urandom); x1 = 1'($urandom); y1 = 1'($urandom); c1 = 1'($urandom);
      v8 = 1'($urandom); x8 = 8'($urandom); y8 = 8'($urandom); c8 = 1'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
